// File: rtl/mrsc_pkg.sv
// Shared MRSC codeword layout and encode function.
// The encoder and decoder both import this package so they agree on bit placement.
package mrsc_pkg;

  localparam int DATA_W = 16;
  localparam int CW_W   = 32;

  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 16;
  localparam int DIAG_MSB = 15;
  localparam int DIAG_LSB = 12;
  localparam int PAR_MSB  = 11;
  localparam int PAR_LSB  = 8;
  localparam int CHK_MSB  = 7;
  localparam int CHK_LSB  = 0;

  // Diagonal and parity bits are interleaved as 1,3,2,4 within their nibbles.
  localparam int DIAG1_POS = 15;
  localparam int DIAG3_POS = 14;
  localparam int DIAG2_POS = 13;
  localparam int DIAG4_POS = 12;
  localparam int PAR1_POS  = 11;
  localparam int PAR3_POS  = 10;
  localparam int PAR2_POS  = 9;
  localparam int PAR4_POS  = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [3:0]        diag;
    logic [3:0]        par;
    logic [7:0]        chk;
  } mrsc_cw_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] d;
  } mrsc_nibbles_t;

  function automatic logic [1:0] mrsc_check_pair(input logic [3:0] y);
    return {y[3] ^ y[1], y[2] ^ y[0]};
  endfunction

  function automatic logic [CW_W-1:0] mrsc_encode(input logic [DATA_W-1:0] data);
    mrsc_nibbles_t n;
    mrsc_cw_t      cw;
    logic          di1, di2, di3, di4;
    n   = data;
    di1 = n.a[3] ^ n.b[2] ^ n.c[3] ^ n.d[2];
    di2 = n.a[2] ^ n.b[3] ^ n.c[2] ^ n.d[3];
    di3 = n.a[1] ^ n.b[0] ^ n.c[1] ^ n.d[0];
    di4 = n.a[0] ^ n.b[1] ^ n.c[0] ^ n.d[1];
    cw.data = data;
    cw.diag = {di1, di3, di2, di4};
    cw.par  = {n.a[3] ^ n.b[3] ^ n.c[3] ^ n.d[3],
               n.a[1] ^ n.b[1] ^ n.c[1] ^ n.d[1],
               n.a[2] ^ n.b[2] ^ n.c[2] ^ n.d[2],
               n.a[0] ^ n.b[0] ^ n.c[0] ^ n.d[0]};
    cw.chk  = {mrsc_check_pair(n.a), mrsc_check_pair(n.b),
               mrsc_check_pair(n.c), mrsc_check_pair(n.d)};
    return cw;
  endfunction

endpackage

// File: rtl/mrsc_pipe_stage.sv
// Single valid/ready register slice; holds its contents while downstream stalls.
module mrsc_pipe_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  // Data only moves on a real transfer so the output stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/mrsc_encoder_pipe.sv
// Two-stage MRSC encoder: stage 1 captures data and fault mask, stage 2 encodes and corrupts.
module mrsc_encoder_pipe
  import mrsc_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int INJ_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [CW_W-1:0]   inj_mask,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW_W-1:0]   m_codeword,
  output logic [CNT_W-1:0]  enc_count
);

  localparam int S1_W = CW_W + DATA_W;

  logic              s1_valid;
  logic              s2_ready;
  logic [S1_W-1:0]   s1_data;
  logic [CW_W-1:0]   inj_eff;
  logic [CW_W-1:0]   s2_in;

  assign inj_eff = (INJ_EN != 0) ? inj_mask : '0;

  mrsc_pipe_stage #(.W(S1_W)) u_stage1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_valid),
    .in_ready  (s_ready),
    .in_data   ({inj_eff, s_data}),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  always_comb begin
    s2_in = mrsc_encode(s1_data[DATA_W-1:0]) ^ s1_data[S1_W-1:DATA_W];
  end

  mrsc_pipe_stage #(.W(CW_W)) u_stage2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_codeword)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_count <= '0;
    end else if (m_valid && m_ready) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mrsc_encoder_pipe.sv
// Bench for mrsc_encoder_pipe: three configurations share one stimulus stream
// and are compared against a scoreboard fed by a nibble-level reference encoder.
module tb_mrsc_encoder_pipe;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic [31:0] inj_mask;
  logic        m_ready;

  logic        s_ready_a, s_ready_n, s_ready_c;
  logic        m_valid_a, m_valid_n, m_valid_c;
  logic [31:0] cw_a, cw_n, cw_c;
  logic [15:0] cnt_a, cnt_n;
  logic [1:0]  cnt_c;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] data;
    logic [31:0] mask;
    logic [31:0] exp_inj;
    logic [31:0] exp_noinj;
  } vec_t;

  typedef struct {
    logic [31:0] cw_inj;
    logic [31:0] cw_noinj;
  } exp_t;

  vec_t        vecs[5];
  exp_t        sb[$];
  exp_t        sb_head;
  int unsigned cnt_model;
  bit          stall_prev;
  logic [31:0] stall_cw;

  mrsc_encoder_pipe #(.CNT_W(16), .INJ_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
    .inj_mask(inj_mask), .m_valid(m_valid_a), .m_ready(m_ready), .m_codeword(cw_a),
    .enc_count(cnt_a));

  mrsc_encoder_pipe #(.CNT_W(16), .INJ_EN(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_n), .s_data(s_data),
    .inj_mask(inj_mask), .m_valid(m_valid_n), .m_ready(m_ready), .m_codeword(cw_n),
    .enc_count(cnt_n));

  mrsc_encoder_pipe #(.CNT_W(2), .INJ_EN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_c), .s_data(s_data),
    .inj_mask(inj_mask), .m_valid(m_valid_c), .m_ready(m_ready), .m_codeword(cw_c),
    .enc_count(cnt_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Paper-level model: nibbles A..D, bit index p=1..4 is bit 4-p; B and D use the swapped partner index on diagonals.
  function automatic logic [31:0] refEncode(input logic [15:0] d, input logic [31:0] mask, input bit use_mask);
    logic [3:0]  nib[4];
    logic        dv[5];
    logic        pv[5];
    int          order[4];
    int          q;
    logic [15:0] low;
    logic [31:0] cw;
    order[0] = 1; order[1] = 3; order[2] = 2; order[3] = 4;
    for (int i = 0; i < 4; i++) nib[i] = d[15-4*i -: 4];
    for (int k = 1; k <= 4; k++) begin
      dv[k] = 1'b0;
      pv[k] = 1'b0;
      for (int i = 0; i < 4; i++) begin
        q = (i % 2 == 1) ? ((k % 2 == 1) ? k + 1 : k - 1) : k;
        pv[k] = pv[k] ^ nib[i][4-k];
        dv[k] = dv[k] ^ nib[i][4-q];
      end
    end
    dv[0] = 1'b0;
    pv[0] = 1'b0;
    low = 16'h0;
    for (int j = 0; j < 4; j++) low = (low << 1) | 16'(dv[order[j]]);
    for (int j = 0; j < 4; j++) low = (low << 1) | 16'(pv[order[j]]);
    for (int i = 0; i < 4; i++)
      low = (low << 2) | 16'({nib[i][3] ^ nib[i][1], nib[i][2] ^ nib[i][0]});
    cw = {d, low};
    if (use_mask) cw = cw ^ mask;
    return cw;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: decides each transfer half a cycle before the edge that performs it.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("count_w16", {16'h0, cnt_a}, 32'(cnt_model % 65536));
      checkOutput("count_w2", {30'h0, cnt_c}, 32'(cnt_model % 4));
      if (stall_prev) begin
        checkOutput("hold_valid", {31'h0, m_valid_a}, 32'h1);
        checkOutput("hold_cw", cw_a, stall_cw);
      end
      if (m_valid_a && m_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", {31'h0, m_valid_a}, 32'h0);
        end else begin
          sb_head = sb.pop_front();
          checkOutput("sb_cw_inj", cw_a, sb_head.cw_inj);
          checkOutput("sb_cw_w2", cw_c, sb_head.cw_inj);
          checkOutput("sb_cw_noinj", cw_n, sb_head.cw_noinj);
        end
        cnt_model++;
      end
      stall_prev = m_valid_a && !m_ready;
      stall_cw   = cw_a;
      if (s_valid && s_ready_a)
        sb.push_back('{refEncode(s_data, inj_mask, 1'b1), refEncode(s_data, inj_mask, 1'b0)});
    end
  end

  task automatic clearModel();
    sb.delete();
    cnt_model  = 0;
    stall_prev = 1'b0;
  endtask

  task automatic doReset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    clearModel();
    #3;
    checkOutput("rst_m_valid", {31'h0, m_valid_a}, 32'h0);
    checkOutput("rst_cw", cw_a, 32'h0);
    checkOutput("rst_count", {16'h0, cnt_a}, 32'h0);
    checkOutput("rst_s_ready", {31'h0, s_ready_a}, 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Presents a word and returns 1ns after the edge that accepted it.
  task automatic applyStimulus(input logic [15:0] d, input logic [31:0] mask);
    bit acc;
    s_valid  = 1'b1;
    s_data   = d;
    inj_mask = mask;
    for (int t = 0; t < 40; t++) begin
      #1 acc = s_ready_a;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    checkOutput("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [15:0] words[6];
  bit          acc_r;

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 16'h0;
    inj_mask = 32'h0;
    m_ready  = 1'b0;
    clearModel();

    vecs[0] = '{16'h0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[1] = '{16'h8000, 32'h0000_0000, 32'h8000_8880, 32'h8000_8880};
    vecs[2] = '{16'h0001, 32'h0000_0000, 32'h0001_4101, 32'h0001_4101};
    vecs[3] = '{16'hFFFF, 32'h0000_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    vecs[4] = '{16'h8000, 32'h0000_0080, 32'h8000_8800, 32'h8000_8880};

    // Known vectors, one at a time, checking the two-cycle latency.
    doReset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].data, vecs[i].mask);
      s_valid = 1'b0;
      checkOutput("lat_early", {31'h0, m_valid_a}, 32'h0);
      @(posedge clk); #1;
      checkOutput("vec_valid", {31'h0, m_valid_a}, 32'h1);
      checkOutput("vec_cw_inj", cw_a, vecs[i].exp_inj);
      checkOutput("vec_cw_noinj", cw_n, vecs[i].exp_noinj);
      @(posedge clk); #1;
      checkOutput("vec_count", {16'h0, cnt_a}, 32'(i + 1));
    end

    // Eight back-to-back words at full throughput.
    doReset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(16'($urandom), 32'h0);
      checkOutput("burst_s_ready", {31'h0, s_ready_a}, 32'h1);
      if (i >= 1) checkOutput("burst_m_valid", {31'h0, m_valid_a}, 32'h1);
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("burst_last_valid", {31'h0, m_valid_a}, 32'h1);
    @(posedge clk); #1;
    checkOutput("burst_end_valid", {31'h0, m_valid_a}, 32'h0);
    checkOutput("burst_count", {16'h0, cnt_a}, 32'h8);

    // Narrow counter wraps after four transfers.
    doReset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(16'($urandom), 32'h0);
    idle(3);
    checkOutput("wrap_count_w2", {30'h0, cnt_c}, 32'h1);
    checkOutput("wrap_count_w16", {16'h0, cnt_a}, 32'h5);

    // Backpressure: pipeline fills after two accepts and holds its output.
    doReset();
    for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
    m_ready = 1'b0;
    applyStimulus(words[0], 32'h0);
    applyStimulus(words[1], 32'h0);
    checkOutput("stall_s_ready", {31'h0, s_ready_a}, 32'h0);
    checkOutput("stall_m_valid", {31'h0, m_valid_a}, 32'h1);
    checkOutput("stall_cw", cw_a, refEncode(words[0], 32'h0, 1'b1));
    s_data = words[2];
    for (int t = 0; t < 3; t++) begin
      @(posedge clk); #1;
      checkOutput("stall_hold_ready", {31'h0, s_ready_a}, 32'h0);
      checkOutput("stall_hold_cw", cw_a, refEncode(words[0], 32'h0, 1'b1));
    end
    m_ready = 1'b1;
    for (int i = 2; i < 6; i++) applyStimulus(words[i], 32'h0);
    idle(5);
    checkOutput("stall_drained", 32'(sb.size()), 32'h0);
    checkOutput("stall_count", {16'h0, cnt_a}, 32'h6);

    // Asynchronous reset in the middle of a stream.
    doReset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), 32'($urandom));
    checkOutput("pre_rst_count", {16'h0, cnt_a}, 32'h2);
    #2 rst_n = 1'b0;
    s_valid = 1'b0;
    clearModel();
    #1;
    checkOutput("midrst_m_valid", {31'h0, m_valid_a}, 32'h0);
    checkOutput("midrst_count", {16'h0, cnt_a}, 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postrst_idle", {31'h0, m_valid_a}, 32'h0);
    words[0] = 16'h5A3C;
    applyStimulus(words[0], 32'h0);
    s_valid = 1'b0;
    checkOutput("postrst_early", {31'h0, m_valid_a}, 32'h0);
    @(posedge clk); #1;
    checkOutput("postrst_valid", {31'h0, m_valid_a}, 32'h1);
    checkOutput("postrst_cw", cw_a, refEncode(words[0], 32'h0, 1'b1));

    // Randomised traffic with random backpressure and occasional fault masks.
    doReset();
    s_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if (!s_valid || acc_r) begin
        s_valid  = ($urandom_range(0, 2) != 0);
        s_data   = 16'($urandom);
        inj_mask = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0;
      end
      #1 acc_r = s_valid && s_ready_a;
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    idle(6);
    checkOutput("rand_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
